// File: rtl/lif_scheduler_if.sv
// rtl/lif_scheduler_if.sv - host/consumer port bundle of the LIF scheduler
interface lif_scheduler_if #(
  parameter int NEURONS = 8,
  parameter int IDXW    = 3
);
  logic               tick;
  logic               cfg_we;
  logic [IDXW-1:0]    cfg_addr;
  logic [7:0]         cfg_data;
  logic [IDXW-1:0]    rd_addr;
  logic [7:0]         rd_state;
  logic               busy;
  logic               done;
  logic               overrun;
  logic [NEURONS-1:0] spike_vec;
  logic               ev_valid;
  logic [IDXW-1:0]    ev_idx;
  logic               ev_ready;

  modport master (
    output tick, cfg_we, cfg_addr, cfg_data, rd_addr, ev_ready,
    input  rd_state, busy, done, overrun, spike_vec, ev_valid, ev_idx
  );

  modport slave (
    input  tick, cfg_we, cfg_addr, cfg_data, rd_addr, ev_ready,
    output rd_state, busy, done, overrun, spike_vec, ev_valid, ev_idx
  );
endinterface

// File: rtl/lif_scheduler.sv
// rtl/lif_scheduler.sv - time-multiplexed leaky integrate-and-fire engine with spike event FIFO
module lif_scheduler #(
  parameter int NEURONS    = 8,
  parameter int IDXW       = 3,
  parameter int THRESH     = 200,
  parameter int LEAK_SHIFT = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  lif_scheduler_if.slave  bus
);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE, SWEEP} state_e;

  state_e             st_q, st_d;
  logic [IDXW-1:0]    idx_q, idx_d;
  logic               pending_q, pending_d;
  logic               overrun_q, overrun_d;
  logic               done_q, done_d;

  logic [7:0]         mem_q [NEURONS];
  logic [7:0]         cur_q [NEURONS];
  logic [NEURONS-1:0] spike_q;
  logic [IDXW-1:0]    fifo_q [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [PW:0]        count_q;

  logic [7:0]         s_cur, c_cur, leaked;
  logic [8:0]         sum;
  logic               fire, fifo_full, in_sweep, stall, commit, last, push, pop;

  // Sum is kept at 9 bits so large state+current never wraps below threshold.
  assign s_cur     = mem_q[idx_q];
  assign c_cur     = cur_q[idx_q];
  assign leaked    = s_cur - (s_cur >> LEAK_SHIFT);
  assign sum       = {1'b0, leaked} + {1'b0, c_cur};
  assign fire      = (sum >= 9'(THRESH));
  assign fifo_full = (count_q == (PW+1)'(FIFO_DEPTH));
  assign in_sweep  = (st_q == SWEEP);
  assign stall     = in_sweep && fire && fifo_full;
  assign commit    = in_sweep && !stall;
  assign last      = (idx_q == IDXW'(NEURONS - 1));
  assign push      = commit && fire;
  assign pop       = (count_q != '0) && bus.ev_ready;

  always_comb begin
    st_d      = st_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    done_d    = 1'b0;
    case (st_q)
      IDLE: begin
        if (bus.tick || pending_q) begin
          st_d      = SWEEP;
          idx_d     = '0;
          pending_d = 1'b0;
          if (bus.tick && pending_q) overrun_d = 1'b1;
        end
      end
      SWEEP: begin
        if (bus.tick) begin
          if (pending_q) overrun_d = 1'b1;
          else           pending_d = 1'b1;
        end
        if (commit) begin
          if (last) begin
            st_d   = IDLE;
            done_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q      <= IDLE;
      idx_q     <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      st_q      <= st_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      done_q    <= done_d;
    end
  end

  // Config writes land regardless of FSM state; a same-cycle commit reads the old current.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NEURONS; i++) begin
        mem_q[i] <= 8'd0;
        cur_q[i] <= 8'd0;
      end
      for (int j = 0; j < FIFO_DEPTH; j++) fifo_q[j] <= '0;
      spike_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (bus.cfg_we) cur_q[bus.cfg_addr] <= bus.cfg_data;
      if (commit) begin
        mem_q[idx_q]   <= fire ? 8'd0 : sum[7:0];
        spike_q[idx_q] <= fire;
      end
      if (push) begin
        fifo_q[wr_ptr_q] <= idx_q;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  assign bus.rd_state  = mem_q[bus.rd_addr];
  assign bus.busy      = in_sweep;
  assign bus.done      = done_q;
  assign bus.overrun   = overrun_q;
  assign bus.spike_vec = spike_q;
  assign bus.ev_valid  = (count_q != '0);
  assign bus.ev_idx    = fifo_q[rd_ptr_q];
endmodule

// File: doc/lif_scheduler.md
# lif_scheduler

Time-multiplexed leaky integrate-and-fire (LIF) engine that shares one membrane-update datapath among `NEURONS` virtual neurons. Each neuron holds an 8-bit membrane state and an 8-bit input current in local registers. A `tick` pulse starts one sweep, which updates every neuron once, one per cycle, in index order. Spike events are queued in a small FIFO with a valid/ready output port, so the block sits between a host or stimulus generator and downstream spike consumers or output muxes.

## Interface
Parameters:
- `NEURONS`, 8: number of virtual neurons; power of two, 2..64.
- `IDXW`, 3: index width; must equal clog2(`NEURONS`).
- `THRESH`, 200: firing threshold, 1..255.
- `LEAK_SHIFT`, 1: leak amount per update is state >> `LEAK_SHIFT`; range 1..7.
- `FIFO_DEPTH`, 4: spike event FIFO depth; power of two, at least 2.

Ports:
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `tick`  in  1  request one sweep; level sampled each cycle.
- `cfg_we`  in  1  write enable for a current register.
- `cfg_addr`  in  `IDXW`  index of the current register to write.
- `cfg_data`  in  8  current value to write.
- `rd_addr`  in  `IDXW`  membrane read index.
- `rd_state`  out  8  membrane state of `rd_addr`; combinational read.
- `busy`  out  1  high while a sweep is in progress.
- `done`  out  1  one-cycle pulse when a sweep completes.
- `overrun`  out  1  sticky flag: a tick was lost; cleared only by `rst`.
- `spike_vec`  out  `NEURONS`  spike bit per neuron from its most recent update.
- `ev_valid`  out  1  FIFO not empty.
- `ev_idx`  out  `IDXW`  index of the neuron at the FIFO head.
- `ev_ready`  in  1  consumer accepts the head entry; pops when `ev_valid` and `ev_ready` are both high.

## Operation
- Reset values:
  - All membrane states, current registers and `spike_vec` are 0.
  - The FIFO is empty.
  - FSM is in IDLE.
  - `busy`, `done`, `overrun` and `ev_valid` are 0.
  - The pending flag is cleared.
- FSM states:
  - IDLE: when `tick`=1 or pending=1, load idx=0, clear pending, go to SWEEP.
  - SWEEP: process neuron idx each cycle.
    - If the commit is not stalled and idx=`NEURONS`-1, go to IDLE and pulse `done`. If pending is set at that point, IDLE starts the next sweep on the following cycle.
    - Otherwise, if not stalled, increment idx.
- Update arithmetic for neuron idx, with s = state and c = current:
  - leaked = s − (s >> `LEAK_SHIFT`).
  - sum = leaked + c, computed at 9 bits with no wrap.
  - If sum ≥ `THRESH`: spike. Set state to 0, set `spike_vec[idx]`=1, push idx into the FIFO.
  - Otherwise: set state to sum[7:0] and clear `spike_vec[idx]`.
- Stall rule:
  - Applies when a spike would occur and the FIFO is full.
  - Nothing is committed and idx holds; the update is re-evaluated next cycle.
  - A pop in the same cycle does not lift the stall.
  - Non-spiking updates never stall.
- Tick handling:
  - `tick` in IDLE starts a sweep.
  - `tick` during SWEEP sets pending.
  - `tick` while pending is already set sets `overrun`; the extra tick is dropped.
- Configuration writes:
  - `cfg_we` is accepted in any state and takes effect at the edge.
  - If `cfg_addr` equals the idx being committed in the same cycle, the update uses the old current. The new value applies from the next sweep.
- FIFO: ordered by commit. `ev_idx` is the head entry; pop happens on `ev_valid` && `ev_ready`.

## Timing
- Sweep start: `tick` sampled at edge k (FSM in IDLE, no stalls) → `busy`=1 after edge k. Neuron i is committed at edge k+1+i.
- Sweep end: `done`=1 and `busy`=0 after edge k+`NEURONS`. `done` lasts one cycle.
- Sweep length: each stall cycle extends the sweep by one cycle.
- Event latency: a spike commits at edge e → `ev_valid`=1 after edge e, when the FIFO was previously empty.
- Readback: `rd_state` reflects a commit in the cycle after its edge.
- Reset mid-sweep: `rst` is asynchronous and takes effect immediately. All reset values apply and no partial sweep resumes.

## Test plan
- Basic fire, THRESH=200, LEAK_SHIFT=1:
  - Stimulus: write current 150 to neuron 2, then tick.
  - Sweep 1 → state[2]=150, no event.
  - Sweep 2 → 75+150=225 ≥ 200, so state[2]=0, `spike_vec[2]`=1, `ev_idx`=2.
- No-wrap compare: state 250, current 255 → 9-bit sum 380 → spike; state 0 (not the wrapped value 124).
- Backpressure:
  - Stimulus: all 8 currents =255, `ev_ready`=0, tick.
  - Neurons 0..3 fill the FIFO; the sweep stalls at idx 4 with `busy` held high.
  - Raise `ev_ready` → events pop in order 0..7; `done` follows the commit of neuron 7.
- Tick queuing:
  - One tick mid-sweep → a second sweep starts the cycle after `done`, `overrun`=0.
  - Two ticks mid-sweep → `overrun`=1 and only one extra sweep runs.
- Config collision: write cfg to neuron 3 in the exact cycle neuron 3 commits → that update uses the old current and the next sweep uses the new one.
- Mid-sweep reset: assert `rst` with idx=5 → all states 0, FIFO empty, `busy`=0 immediately. A later tick runs a full sweep from idx 0.
